// File: rtl/mem_bus_if.sv
// mem_bus_if: bridges the internal datapath bus to a multiplexed external address/data memory bus.
// Latency: ALE sampled high -> Ready pulse 3 cycles later with zero wait states.
// Backpressure: nWait (active-low) stretches READ/WRITE when MEM_BUS_WAIT_EN is defined.
//   Without the macro, nWait is ignored.
//   With the macro, a 4-bit counter aborts the access after 15 extended cycles.
//
// Ports:
//   Clock, nReset          clock and asynchronous active-low reset
//   SysBusOut / SysBusIn   datapath to memory (address on ALE, then store data) / read data (gated by ENB)
//   ALE, nWE, ENB          access start, write select (sampled in ADDR), read-data output enable
//   AdIn / AdOut / AdOe    external multiplexed pad input / output / output enable
//   ExtAle, ExtnME, ExtnOE, ExtnWE   external strobes (ExtAle active-high, others active-low)
//   nWait                  external wait request, active-low
//   Ready, BusErr          one-cycle completion pulse / sticky error flag
module mem_bus_if (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] SysBusOut,
  output logic [15:0] SysBusIn,
  input  logic        ALE,
  input  logic        nWE,
  input  logic        ENB,
  input  logic [15:0] AdIn,
  output logic [15:0] AdOut,
  output logic        AdOe,
  output logic        ExtAle,
  output logic        ExtnME,
  output logic        ExtnOE,
  output logic        ExtnWE,
  input  logic        nWait,
  output logic        Ready,
  output logic        BusErr
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_READ, S_WRITE, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_addr;
  logic [15:0] r_wrdata;
  logic [15:0] r_rddata;
  logic        r_buserr;
  logic        w_in_data;   // READ or WRITE phase
  logic        w_last;      // final cycle of the READ/WRITE phase
  logic        w_abort;     // wait timeout on this cycle

  assign w_in_data = (r_state == S_READ) || (r_state == S_WRITE);

`ifdef MEM_BUS_WAIT_EN
  logic [3:0] r_wait_cnt;

  // The counter holds the number of cycles already extended in this phase.
  // If nWait is still low once 15 extensions have elapsed, the access is abandoned.
  assign w_abort = w_in_data && !nWait && (r_wait_cnt == 4'hF);
  assign w_last  = nWait || w_abort;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_wait_cnt <= 4'h0;
    end else if (w_in_data && !w_last) begin
      r_wait_cnt <= r_wait_cnt + 4'h1;
    end else begin
      r_wait_cnt <= 4'h0;
    end
  end
`else
  logic w_unused_nwait;

  assign w_unused_nwait = nWait;
  assign w_abort        = 1'b0;
  assign w_last         = 1'b1;
`endif

  // State register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and strobe decode. Every pin is a function of state or registers only.
  always_comb begin
    w_next = r_state;
    AdOut  = r_addr;
    AdOe   = 1'b0;
    ExtAle = 1'b0;
    ExtnME = 1'b1;
    ExtnOE = 1'b1;
    ExtnWE = 1'b1;
    Ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ALE) w_next = S_ADDR;
      end
      S_ADDR: begin
        AdOe   = 1'b1;
        ExtAle = 1'b1;
        ExtnME = 1'b0;
        w_next = nWE ? S_READ : S_WRITE;
      end
      S_READ: begin
        ExtnME = 1'b0;
        ExtnOE = 1'b0;
        if (w_last) w_next = S_HOLD;
      end
      S_WRITE: begin
        AdOut  = r_wrdata;
        AdOe   = 1'b1;
        ExtnME = 1'b0;
        ExtnWE = 1'b0;
        if (w_last) w_next = S_HOLD;
      end
      S_HOLD: begin
        ExtnME = 1'b0;
        Ready  = 1'b1;
        w_next = ALE ? S_ADDR : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address, store data, read data, and error flag
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_addr   <= 16'h0000;
      r_wrdata <= 16'h0000;
      r_rddata <= 16'h0000;
      r_buserr <= 1'b0;
    end else begin
      if (ALE && ((r_state == S_IDLE) || (r_state == S_HOLD))) begin
        r_addr <= SysBusOut;
      end
      if (r_state == S_ADDR) begin
        r_wrdata <= SysBusOut;
      end
      if ((r_state == S_READ) && w_last) begin
        r_rddata <= w_abort ? 16'hFFFF : AdIn;
      end
      // A new ALE in the middle of an access is dropped, but it is flagged.
      if ((ALE && ((r_state == S_ADDR) || w_in_data)) || w_abort) begin
        r_buserr <= 1'b1;
      end
    end
  end

  assign BusErr   = r_buserr;
  assign SysBusIn = ENB ? r_rddata : 16'h0000;

endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: transaction-level bench for mem_bus_if.
// Latency: each access is scripted as ADDR, then data cycles, then HOLD.
//   Strobes are compared against the expected pin table for every cycle.
// Backpressure: nWait is driven per data cycle when MEM_BUS_WAIT_EN is defined, and randomly otherwise.
module tb_mem_bus_if;

  logic        Clock  = 1'b0;
  logic        nReset = 1'b1;
  logic [15:0] SysBusOut;
  logic [15:0] SysBusIn;
  logic        ALE;
  logic        nWE;
  logic        ENB;
  logic [15:0] AdIn;
  logic [15:0] AdOut;
  logic        AdOe;
  logic        ExtAle;
  logic        ExtnME;
  logic        ExtnOE;
  logic        ExtnWE;
  logic        nWait;
  logic        Ready;
  logic        BusErr;

  mem_bus_if dut (
    .Clock(Clock), .nReset(nReset), .SysBusOut(SysBusOut), .SysBusIn(SysBusIn),
    .ALE(ALE), .nWE(nWE), .ENB(ENB), .AdIn(AdIn), .AdOut(AdOut), .AdOe(AdOe),
    .ExtAle(ExtAle), .ExtnME(ExtnME), .ExtnOE(ExtnOE), .ExtnWE(ExtnWE),
    .nWait(nWait), .Ready(Ready), .BusErr(BusErr)
  );

  always #5 Clock = ~Clock;

  // Expected pins per bus phase: {AdOe, ExtAle, ExtnME, ExtnOE, ExtnWE, Ready}
  localparam logic [5:0] P_IDLE = 6'b001110;
  localparam logic [5:0] P_ADDR = 6'b110110;
  localparam logic [5:0] P_WR   = 6'b100100;
  localparam logic [5:0] P_RD   = 6'b000010;
  localparam logic [5:0] P_HOLD = 6'b000111;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_rd;    // last completed read data
  logic        m_err;   // sticky error expectation

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] pins();
    return {AdOe, ExtAle, ExtnME, ExtnOE, ExtnWE, Ready};
  endfunction

  task automatic check_bus();
    ENB = 1'($urandom);
    #1;
    chk("sysbusin", 32'(SysBusIn), ENB ? 32'(m_rd) : 32'h0);
    chk("buserr", 32'(BusErr), 32'(m_err));
  endtask

  // Runs one access starting with ALE in the current cycle.
  // Returns in the HOLD cycle, with ALE low, just after the HOLD checks.
  task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] rin, input logic ale_err, input int waits);
    logic last;
    logic abort;
    last  = 1'b0;
    abort = 1'b0;
    ALE       = 1'b1;
    SysBusOut = addr;
    nWE       = 1'($urandom);
    @(negedge Clock);
    chk("addr_pins", 32'(pins()), 32'(P_ADDR));
    chk("addr_adout", 32'(AdOut), 32'(addr));
    ALE       = 1'b0;
    nWE       = ~wr;
    SysBusOut = wdata;
    for (int k = 0; k < 16; k++) begin
      @(negedge Clock);
      chk(wr ? "wr_pins" : "rd_pins", 32'(pins()), wr ? 32'(P_WR) : 32'(P_RD));
      if (wr) chk("wr_adout", 32'(AdOut), 32'(wdata));
      ALE       = ale_err && (k == 0);
      if (ale_err && (k == 0)) m_err = 1'b1;
      nWE       = 1'($urandom);
      SysBusOut = 16'($urandom);
`ifdef MEM_BUS_WAIT_EN
      nWait = (k < waits) ? 1'b0 : 1'b1;
      last  = nWait || (k == 15);
      abort = !nWait && (k == 15);
`else
      nWait = 1'($urandom);
      last  = 1'b1;
      abort = 1'b0;
      if (waits < 0) last = 1'b1;
`endif
      AdIn = last ? rin : 16'($urandom);
      if (last) break;
    end
    @(negedge Clock);
    ALE   = 1'b0;
    nWait = 1'b1;
    chk("hold_pins", 32'(pins()), 32'(P_HOLD));
    if (!wr) m_rd = abort ? 16'hFFFF : rin;
    if (abort) m_err = 1'b1;
    check_bus();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ALE       = 1'b0;
      SysBusOut = 16'($urandom);
      nWE       = 1'($urandom);
      nWait     = 1'($urandom);
      AdIn      = 16'($urandom);
      @(negedge Clock);
      chk("idle_pins", 32'(pins()), 32'(P_IDLE));
      check_bus();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ALE = 1'b0; nWE = 1'b1; ENB = 1'b0; SysBusOut = 16'h0; AdIn = 16'h0; nWait = 1'b1;
    m_rd = 16'h0; m_err = 1'b0;
    #1 nReset = 1'b0;
    #1;
    chk("rst_pins", 32'(pins()), 32'(P_IDLE));
    chk("rst_buserr", 32'(BusErr), 32'h0);
    ENB = 1'b1;
    #1 chk("rst_sysbusin", 32'(SysBusIn), 32'h0);
    @(negedge Clock);
    nReset = 1'b1;
    // The first ALE after reset must be taken on the very next edge.
    access(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 0);
    idle(1);

    // Directed read, then directed write (read data must survive the write).
    access(1'b0, 16'h1234, 16'h0000, 16'hBEEF, 1'b0, 0);
    ENB = 1'b1;
    #1 chk("read_beef", 32'(SysBusIn), 32'h0000BEEF);
    idle(1);
    access(1'b1, 16'h0040, 16'hA5A5, 16'h0000, 1'b0, 0);
    ENB = 1'b1;
    #1 chk("write_keeps_rd", 32'(SysBusIn), 32'h0000BEEF);

    // Back-to-back: ALE in HOLD goes straight to ADDR.
    access(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 0);
    access(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 0);
    idle(1);

    // Randomised traffic with random gaps (zero gap means back-to-back).
    for (int t = 0; t < 24; t++) begin
      access(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0,
             int'($urandom_range(0, 4)));
      idle(int'($urandom_range(0, 2)));
    end

`ifdef MEM_BUS_WAIT_EN
    idle(1);
    access(1'b0, 16'($urandom), 16'($urandom), 16'h1357, 1'b0, 3);
    idle(1);
    access(1'b0, 16'($urandom), 16'($urandom), 16'h2468, 1'b0, 20);
    ENB = 1'b1;
    #1 chk("abort_ffff", 32'(SysBusIn), 32'h0000FFFF);
    chk("abort_buserr", 32'(BusErr), 32'h1);
`endif

    // ALE during a read is dropped, but it flags BusErr until reset.
    idle(1);
    access(1'b0, 16'($urandom), 16'($urandom), 16'h0F0F, 1'b1, 0);
    idle(2);
    access(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 0);
    chk("buserr_sticky", 32'(BusErr), 32'h1);
    idle(1);

    // Reset asserted in the middle of a write.
    ALE = 1'b1; SysBusOut = 16'h0077;
    @(negedge Clock);
    chk("rw_addr_pins", 32'(pins()), 32'(P_ADDR));
    ALE = 1'b0; nWE = 1'b0; SysBusOut = 16'h5A5A;
    @(negedge Clock);
    chk("rw_wr_pins", 32'(pins()), 32'(P_WR));
    nReset = 1'b0;
    #1;
    chk("rw_rst_pins", 32'(pins()), 32'(P_IDLE));
    chk("rw_rst_buserr", 32'(BusErr), 32'h0);
    ENB = 1'b1;
    #0 chk("rw_rst_rd", 32'(SysBusIn), 32'h0);
    m_rd = 16'h0; m_err = 1'b0;
    #1 nReset = 1'b1;
    access(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
